game_timer: RTL
===============

GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL have parameter FRAMES_PER_SEC, default 60, meaning frame pulses per displayed second (legal range 1..255).
REQ-002 SHALL have parameter START_SECONDS, default 60, meaning initial countdown value in seconds (legal range 1..99).
REQ-003 SHALL have port clk  input  1  system clock; the single clock, all logic rises on it.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port frame_clk  input  1  frame strobe from the VGA controller, asynchronous to clk, high at least 3 clk periods.
REQ-006 SHALL have port state  input  2  game FSM encoding: 2'h3 Intro, 2'h0 Start, 2'h1 Game, 2'h2 End.
REQ-007 SHALL have port time_tens  output  4  BCD tens digit of remaining seconds.
REQ-008 SHALL have port time_ones  output  4  BCD ones digit of remaining seconds.
REQ-009 SHALL have port second_tick  output  1  one-cycle pulse on each countdown decrement.
REQ-010 SHALL have port game_over_check  output  1  level, high once the countdown has reached 00; feeds the game FSM.

Function
REQ-011 SHALL synchronise frame_clk through two flops and detect its rising edge, producing a one-cycle frame_pulse.
REQ-012 SHALL have a frame_clk rising edge affect the registered outputs exactly 3 clk cycles later (2 sync stages, then 1 counter update).
REQ-013 SHALL, in Intro or Start, hold the frame counter at 0, load time_tens/time_ones with the BCD of START_SECONDS, and hold game_over_check low, every cycle.
REQ-014 SHALL, in Game, count frame_pulse events with an 8-bit frame counter modulo FRAMES_PER_SEC.
REQ-015 SHALL, when frame_pulse occurs with the frame counter at FRAMES_PER_SEC-1 in Game, wrap the counter to 0, decrement the BCD value by one, and pulse second_tick for that cycle.
REQ-016 SHALL perform BCD decrement as follows: ones>0 gives ones-1; ones==0 and tens>0 gives ones=9 and tens-1.
REQ-017 SHALL set game_over_check in the same clock edge that loads 00 into the digits.
REQ-018 SHALL saturate at 00: no further decrement and no second_tick while the digits are 00; game_over_check stays high.
REQ-019 SHALL, in End, freeze the digits, the frame counter and game_over_check, and hold second_tick low.
REQ-020 SHALL decide on the sampled state value alone when state changes in the same cycle as a frame_pulse; a pulse outside Game is discarded.
REQ-021 SHALL treat a direct End to Start/Intro transition as a full reload per REQ-013.
REQ-022 SHALL never let the BCD digits hold a value above 9.

Reset
REQ-023 SHALL, on Reset low, asynchronously clear the sync flops and the frame counter, load the digits with the BCD of START_SECONDS, and drive second_tick and game_over_check to 0.
REQ-024 SHALL, on Reset assertion mid-countdown, abandon the count immediately, with no partial second retained after release.
REQ-025 SHALL ignore any frame_clk edge present at reset release unless it is seen rising after release.

Structure
REQ-026 SHALL take the state encodings ST_INTRO=2'h3, ST_START=2'h0, ST_GAME=2'h1 and ST_END=2'h2 from shared package game_pkg, also used by the game FSM.
REQ-027 SHALL place the BCD split of START_SECONDS in a game_pkg function and not duplicate it in the RTL.
REQ-028 SHALL implement the synchroniser and edge detector as sub-module sync_edge (ports clk, Reset, d, pulse), instantiated once.

Verification
(Parameters FRAMES_PER_SEC=2, START_SECONDS=3 unless stated.)
REQ-029 SHALL check: Reset low then high, state=Start -> digits 0,3; game_over_check 0; second_tick 0.
REQ-030 SHALL check: state=Game, 2 frame_clk pulses -> digits 0,2, a single second_tick 3 cycles after the 2nd rise; 4 more pulses -> 00 with game_over_check 1 on that same edge.
REQ-031 SHALL check: at 00, 6 further pulses -> digits stay 00, no second_tick, game_over_check stays 1.
REQ-032 SHALL check: START_SECONDS=10, FRAMES_PER_SEC=1, 1 pulse in Game -> tens 0, ones 9 (borrow).
REQ-033 SHALL check: 1 pulse in Game, then state=End, then 4 pulses -> digits stay 0,3 and the frame counter stays at 1; state back to Start -> reload to 0,3 and frame counter 0.
REQ-034 SHALL check: Reset pulsed low mid-Game with digits 0,1 -> asynchronous reload to 0,3 and game_over_check 0 before the next clk edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: state encoding used by the game FSM and the timer,
// plus the BCD split helper for the countdown start value.
package game_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'h0,
    ST_GAME  = 2'h1,
    ST_END   = 2'h2,
    ST_INTRO = 2'h3
  } state_t;

  // Split a 0..99 value into packed {tens, ones} BCD digits.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with rising-edge detector for an asynchronous strobe.
// The edge detector is only armed once its history flop holds a sample taken
// after reset release, so a level already high at release is never a "rise".
module sync_edge (
  input  logic clk,
  input  logic Reset,
  input  logic d,
  output logic pulse
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic [2:0] r_arm;

  // Synchroniser chain, edge history and post-reset arming shift register
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_arm <= 3'b000;
    end else begin
      r_s1  <= d;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_arm <= {r_arm[1:0], 1'b1};
    end
  end

  assign pulse = r_s2 & ~r_s3 & r_arm[2];

endmodule

// File: rtl/game_timer.sv
// Countdown game timer: counts frame strobes while in Game, decrements a
// two-digit BCD seconds value once per FRAMES_PER_SEC frames, saturates at 00.
module game_timer
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int START_SECONDS  = 60
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [1:0] state,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic       second_tick,
  output logic       game_over_check
);

  localparam logic [7:0] START_BCD = to_bcd(START_SECONDS);
  localparam logic [7:0] FPS_M1    = 8'(FRAMES_PER_SEC - 1);

  logic       w_frame_pulse;
  state_t     w_state;
  logic [7:0] w_digits;
  logic [7:0] w_digits_dec;
  logic [7:0] r_frame_cnt;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       r_tick;
  logic       r_game_over;

  // One-step BCD decrement with borrow from tens; holds at 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = v[7:4];
    o = v[3:0];
    if (o != 4'd0)      return {t, o - 4'd1};
    else if (t != 4'd0) return {t - 4'd1, 4'd9};
    else                return 8'h00;
  endfunction

  sync_edge u_sync_edge (
    .clk   (clk),
    .Reset (Reset),
    .d     (frame_clk),
    .pulse (w_frame_pulse)
  );

  assign w_state      = state_t'(state);
  assign w_digits     = {r_tens, r_ones};
  assign w_digits_dec = bcd_dec(w_digits);

  // Frame counter, BCD digits, tick and game-over flag, driven by the game state
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_frame_cnt <= 8'd0;
      r_tens      <= START_BCD[7:4];
      r_ones      <= START_BCD[3:0];
      r_tick      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (w_state)
        ST_INTRO, ST_START: begin
          r_frame_cnt <= 8'd0;
          r_tens      <= START_BCD[7:4];
          r_ones      <= START_BCD[3:0];
          r_game_over <= 1'b0;
        end
        ST_GAME: begin
          if (w_frame_pulse) begin
            if (r_frame_cnt == FPS_M1) begin
              r_frame_cnt <= 8'd0;
              if (w_digits != 8'h00) begin
                r_tens <= w_digits_dec[7:4];
                r_ones <= w_digits_dec[3:0];
                r_tick <= 1'b1;
                if (w_digits_dec == 8'h00) r_game_over <= 1'b1;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end
        default: begin
          // End: everything frozen, tick already forced low above
        end
      endcase
    end
  end

  assign time_tens       = r_tens;
  assign time_ones       = r_ones;
  assign second_tick     = r_tick;
  assign game_over_check = r_game_over;

endmodule
